if_stage: RTL and testbench

Instruction-fetch stage of the five-stage RV32 pipeline: owns the PC, drives the instruction-memory request/ack handshake and holds the IF/ID pipeline register. It consumes `stall` (load-use) and `flush` (taken branch, JAL, JALR) from the hazard unit, plus the redirect target from EX. It delivers `{valid, pc, pc+4, ir}` to decode.

---
 rtl/if_stage.sv | 147 ++++++++++++++
 tb/tb_if_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// RV32 instruction-fetch stage: PC, imem handshake, IF/ID register.
// One-entry skid buffer absorbs a word acked during a stall.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_ir,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    START,
    FETCH,
    HOLD,
    DROP
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ir;
  } if_id_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] buf_ir, buf_ir_n;
  logic [31:0] buf_pc, buf_pc_n;
  logic [31:0] pend_pc, pend_pc_n;
  if_id_t      if_id, if_id_n;
  logic [31:0] pc_inc;
  logic [31:0] buf_inc;

  assign pc_inc  = pc + 32'd4;
  assign buf_inc = buf_pc + 32'd4;

  // state and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= START;
      pc      <= PC_RESET;
      buf_ir  <= '0;
      buf_pc  <= '0;
      pend_pc <= '0;
      if_id   <= '{valid: 1'b0, pc: '0, pc4: '0, ir: NOP};
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      buf_ir  <= buf_ir_n;
      buf_pc  <= buf_pc_n;
      pend_pc <= pend_pc_n;
      if_id   <= if_id_n;
    end
  end

  // next-state, PC steering and IF/ID update
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    buf_ir_n  = buf_ir;
    buf_pc_n  = buf_pc;
    pend_pc_n = pend_pc;
    if_id_n   = if_id;
    unique case (state)
      START: begin
        state_n = FETCH;
      end
      FETCH: begin
        unique case (1'b1)
          imem_ack && flush: begin
            pc_n          = redirect_pc;
            if_id_n.valid = 1'b0;
            if_id_n.ir    = NOP;
          end
          imem_ack && !flush && stall: begin
            buf_pc_n = pc;
            buf_ir_n = imem_rdata;
            pc_n     = pc_inc;
            state_n  = HOLD;
          end
          imem_ack && !flush && !stall: begin
            if_id_n = '{valid: 1'b1, pc: pc,
                        pc4: pc_inc, ir: imem_rdata};
            pc_n    = pc_inc;
          end
          !imem_ack && flush: begin
            pend_pc_n     = redirect_pc;
            if_id_n.valid = 1'b0;
            if_id_n.ir    = NOP;
            state_n       = DROP;
          end
          !imem_ack && !flush && stall: begin
          end
          !imem_ack && !flush && !stall: begin
            if_id_n.valid = 1'b0;
            if_id_n.ir    = NOP;
          end
        endcase
      end
      HOLD: begin
        if (flush) begin
          pc_n          = redirect_pc;
          if_id_n.valid = 1'b0;
          if_id_n.ir    = NOP;
          state_n       = FETCH;
        end else if (!stall) begin
          if_id_n = '{valid: 1'b1, pc: buf_pc,
                      pc4: buf_inc, ir: buf_ir};
          state_n = FETCH;
        end
      end
      DROP: begin
        if (flush) begin
          pend_pc_n = redirect_pc;
        end
        if_id_n.valid = 1'b0;
        if_id_n.ir    = NOP;
        if (imem_ack) begin
          pc_n    = pend_pc_n;
          state_n = FETCH;
        end
      end
    endcase
  end

  assign imem_req    = (state == FETCH) || (state == DROP);
  assign imem_addr   = pc;
  assign fetch_busy  = ((state == FETCH) && !imem_ack) ||
                       (state == DROP);
  assign if_id_valid = if_id.valid;
  assign if_id_pc    = if_id.pc;
  assign if_id_pc4   = if_id.pc4;
  assign if_id_ir    = if_id.ir;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random stall/flush/latency
// checked against a fetch-stream model (word queue + next fetch address).
module tb_if_stage;

  localparam logic [31:0] NOPV = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_id_valid, fetch_busy;
  logic [31:0] if_id_pc, if_id_pc4, if_id_ir;

  logic        s1 = 1'b0;
  logic [31:0] r1 = '0;
  logic        req1, v1, busy1;
  logic [31:0] addr1, pc1, pc41, ir1;

  int          total = 0;
  int          bad = 0;
  int          lat = 0;
  int          wcnt = 0;
  logic [31:0] key = '0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_fa = 32'h0000_3000;
  logic [31:0] pend = '0;
  bit          disc = 0;
  bit          first = 0;
  logic        m_v = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_ir = '0;
  int          ndel = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
    .redirect_pc(redirect_pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_ir(if_id_ir), .fetch_busy(fetch_busy)
  );

  if_stage #(.PC_RESET(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rstn(rstn), .stall(s1), .flush(s1),
    .redirect_pc(r1), .imem_req(req1),
    .imem_addr(addr1), .imem_ack(req1),
    .imem_rdata(addr1), .if_id_valid(v1),
    .if_id_pc(pc1), .if_id_pc4(pc41),
    .if_id_ir(ir1), .fetch_busy(busy1)
  );

  assign imem_ack   = imem_req && (wcnt >= lat);
  assign imem_rdata = imem_addr ^ key;

  // memory wait counter for the current request
  always @(posedge clk or negedge rstn) begin
    if (!rstn) wcnt <= 0;
    else if (!imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic        preq, pack, pst, pfl, ereq, ebusy;
    logic [31:0] pred;
    bit          was_disc;
    ent_t        e;
    @(negedge clk);
    preq = imem_req;
    pack = imem_ack;
    pst  = stall;
    pfl  = flush;
    pred = redirect_pc;
    @(posedge clk);
    #1;
    if (first) begin
      first = 0;
    end else begin
      was_disc = disc;
      if (disc) begin
        if (pfl) pend = pred;
        if (pack) begin
          m_fa = pend;
          disc = 0;
        end
      end else if (pfl) begin
        q.delete();
        if (preq && !pack) begin
          disc = 1;
          pend = pred;
        end else begin
          m_fa = pred;
        end
      end else if (pack) begin
        q.push_back('{m_fa, m_fa ^ key});
        m_fa = m_fa + 32'd4;
      end
      if (pfl || was_disc) begin
        m_v = 1'b0;
      end else if (!pst) begin
        if (q.size() > 0) begin
          e    = q.pop_front();
          m_v  = 1'b1;
          m_pc = e.pc;
          m_ir = e.ir;
          ndel++;
        end else begin
          m_v = 1'b0;
        end
      end
    end
    chk("valid", if_id_valid, m_v);
    if (m_v) begin
      chk("pc", if_id_pc, m_pc);
      chk("pc4", if_id_pc4, m_pc + 32'd4);
      chk("ir", if_id_ir, m_ir);
    end else begin
      chk("nop", if_id_ir, NOPV);
    end
    ereq = (q.size() == 0);
    chk("req", imem_req, ereq);
    if (ereq) chk("addr", imem_addr, m_fa);
    ebusy = ereq && (!(wcnt >= lat) || disc);
    chk("busy", fetch_busy, ebusy);
  endtask

  initial begin
    bit got;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h3000);
    chk("rst_valid", if_id_valid, 0);
    chk("rst_ir", if_id_ir, NOPV);
    chk("rst_pc", if_id_pc, 0);
    chk("rst_pc4", if_id_pc4, 0);
    chk("rst_busy", fetch_busy, 0);
    chk("rst_addr1", addr1, 32'hFFFF_FFFC);

    rstn  = 1'b1;
    first = 1;
    cyc();
    chk("c1_req", imem_req, 1);
    chk("c1_addr", imem_addr, 32'h3000);
    chk("c1_addr1", addr1, 32'hFFFF_FFFC);
    cyc();
    chk("c2_pc", if_id_pc, 32'h3000);
    chk("c2_ir", if_id_ir, 32'h3000);
    chk("c2_addr", imem_addr, 32'h3004);
    chk("wrap_addr", addr1, 32'h0);
    chk("wrap_pc", pc1, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc41, 32'h0);
    cyc();
    chk("c3_pc", if_id_pc, 32'h3004);

    stall = 1'b1;
    cyc();
    chk("lu_hold", if_id_pc, 32'h3004);
    chk("lu_req", imem_req, 0);
    stall = 1'b0;
    cyc();
    chk("lu_3008", if_id_pc, 32'h3008);
    chk("lu_req2", imem_req, 1);
    cyc();
    chk("lu_300c", if_id_pc, 32'h300C);
    chk("f_addr", imem_addr, 32'h3010);

    flush       = 1'b1;
    redirect_pc = 32'h3100;
    cyc();
    flush = 1'b0;
    chk("f_inv", if_id_valid, 0);
    chk("f_nop", if_id_ir, NOPV);
    chk("f_tgt", imem_addr, 32'h3100);
    cyc();
    chk("f_3100", if_id_pc, 32'h3100);
    chk("f_v", if_id_valid, 1);

    lat         = 3;
    flush       = 1'b1;
    redirect_pc = 32'h3200;
    cyc();
    chk("w_addr1", imem_addr, 32'h3104);
    chk("w_busy1", fetch_busy, 1);
    redirect_pc = 32'h3300;
    cyc();
    flush = 1'b0;
    chk("w_addr2", imem_addr, 32'h3104);
    chk("w_busy2", fetch_busy, 1);
    cyc();
    chk("w_addr3", imem_addr, 32'h3104);
    chk("w_ackbusy", fetch_busy, 1);
    cyc();
    chk("w_new", imem_addr, 32'h3300);
    chk("w_inv", if_id_valid, 0);
    lat = 0;
    cyc();
    chk("w_3300", if_id_pc, 32'h3300);

    stall = 1'b1;
    cyc();
    chk("sf_hold", imem_req, 0);
    flush       = 1'b1;
    redirect_pc = 32'h3400;
    cyc();
    stall = 1'b0;
    flush = 1'b0;
    chk("sf_inv", if_id_valid, 0);
    chk("sf_addr", imem_addr, 32'h3400);
    cyc();
    chk("sf_3400", if_id_pc, 32'h3400);

    flush       = 1'b1;
    redirect_pc = 32'h5000;
    cyc();
    flush = 1'b0;
    key   = $urandom;
    ndel  = 0;
    for (int i = 0; i < 3000; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom;
      lat         = $urandom_range(0, 3);
      cyc();
    end
    chk("progress", ndel > 300, 1);

    stall = 1'b0;
    flush = 1'b0;
    lat   = 3;
    got   = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      cyc();
      got = imem_req && !imem_ack;
    end
    chk("outstanding", got, 1);
    rstn = 1'b0;
    #1;
    chk("mr_req", imem_req, 0);
    chk("mr_addr", imem_addr, 32'h3000);
    chk("mr_valid", if_id_valid, 0);
    chk("mr_ir", if_id_ir, NOPV);
    chk("mr_pc", if_id_pc, 0);
    chk("mr_busy", fetch_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
